mips_cpu_fetch: RTL

Instruction-fetch front end for the Harvard MIPS core. It accepts fetch addresses from the PC update logic, reads the instruction memory over a waitrequest-style read port, and buffers fetched words with their PC+4 in a small FIFO. Decode drains that FIFO with a valid/ready handshake. It also handles redirect flushes, including discarding an in-flight read, and the halt-on-address-zero convention.

---
 rtl/mips_cpu_fetch.sv | 110 +++++++++++
 1 files changed

// File: rtl/mips_cpu_fetch.sv
// Instruction-fetch front end: issues waitrequest-style imem reads and buffers
// {instruction, pc+4} pairs in a small FIFO drained by decode.
module mips_cpu_fetch #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] HALT_ADDR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        active
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [1:0] HALTED  = 2'd3;

  logic [1:0]    state, state_next;
  logic [31:0]   addr_reg;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          pop, push, accept, is_halt, fetch_done;

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign fetch_done  = (state == FETCH) && !imem_waitrequest;
  assign push        = fetch_done && !flush;
  assign is_halt     = (pc_in == HALT_ADDR);

  // Projected occupancy counts the in-flight fetch so a granted request always has a free slot.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, (state == FETCH)} - {{CW{1'b0}}, pop};

  assign pc_ready = !flush && ((state == IDLE) || fetch_done) && (occupancy < (CW+1)'(DEPTH));
  assign accept   = pc_valid && pc_ready;

  assign imem_read    = (state == FETCH) || (state == DISCARD);
  assign imem_address = addr_reg;
  assign instr_out    = instr_valid ? instr_mem[rd_ptr] : '0;
  assign pc4_out      = instr_valid ? pc4_mem[rd_ptr] : '0;
  assign active       = (state != HALTED);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = is_halt ? HALTED : FETCH;
      end
      FETCH: begin
        if (flush)             state_next = imem_waitrequest ? DISCARD : IDLE;
        else if (fetch_done)   state_next = accept ? (is_halt ? HALTED : FETCH) : IDLE;
      end
      DISCARD: begin
        if (!imem_waitrequest) state_next = IDLE;
      end
      default: state_next = HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_reg <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (clk_enable) begin
      state <= state_next;
      if (accept && !is_halt) addr_reg <= pc_in;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && clk_enable && push) begin
      instr_mem[wr_ptr] <= imem_readdata;
      pc4_mem[wr_ptr]   <= addr_reg + 32'd4;
    end
  end

endmodule
